// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the memory-stage data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

  localparam logic [1:0] DT_WORD  = 2'b00;
  localparam logic [1:0] DT_HALF  = 2'b01;
  localparam logic [1:0] DT_BYTE  = 2'b10;
  localparam logic [1:0] DT_UBYTE = 2'b11;

  localparam int unsigned TAG_MAX = 30;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        data;
  } line_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  function automatic logic [31:0] lane_extract(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  dt
  );
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    b = w[{off, 3'b000} +: 8];
    unique case (dt)
      DT_WORD:  r = w;
      DT_HALF:  r = {{16{h[15]}}, h};
      DT_BYTE:  r = {{24{b[7]}}, b};
      default:  r = {24'b0, b};
    endcase
    return r;
  endfunction

  function automatic wr_t lane_merge(
    input logic [31:0] wd,
    input logic [1:0]  off,
    input logic [1:0]  dt
  );
    wr_t r;
    unique case (dt)
      DT_WORD: begin
        r.be   = 4'b1111;
        r.data = wd;
      end
      DT_HALF: begin
        r.be   = off[1] ? 4'b1100 : 4'b0011;
        r.data = {16'b0, wd[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        r.be   = 4'b0001 << off;
        r.data = {24'b0, wd[7:0]} << {off, 3'b000};
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_lines.sv
// Direct-mapped line array: async read, byte-enabled sync write,
// valid bits cleared asynchronously on reset.
module dcache_lines
  import dcache_pkg::*;
#(
  parameter int unsigned SETS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  rd_idx,
  output line_t                    rd_line,
  input  logic                     we,
  input  logic [$clog2(SETS)-1:0]  wr_idx,
  input  logic [3:0]               wr_be,
  input  line_t                    wr_line
);

  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_MAX-1:0] tag_q  [SETS];
  logic [TAG_MAX-1:0] tag_d  [SETS];
  logic [31:0]        data_q [SETS];
  logic [31:0]        data_d [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_idx] = wr_line.valid;
      tag_d[wr_idx]   = wr_line.tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_d[wr_idx][8*b +: 8] = wr_line.data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_line.valid = valid_q[rd_idx];
  assign rd_line.tag   = tag_q[rd_idx];
  assign rd_line.data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_mem_stage.sv
// Memory stage with a direct-mapped write-through cache and stall FSM.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_mem_stage
  import dcache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETS          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WE,
  input  logic                     RE,
  input  logic [1:0]               dataType,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  input  logic                     ResultSrc,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     Stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);

  state_t             state_q, state_d;
  logic               wr_hit_q, wr_hit_d;
  logic [IDX_W-1:0]   idx;
  logic [TAG_MAX-1:0] tag;
  line_t              line;
  line_t              wr_line;
  logic [3:0]         wr_be;
  logic               lines_we;
  logic               hit;
  wr_t                merge;

  assign idx   = A[2 +: IDX_W];
  assign tag   = TAG_MAX'(A[ADDRESS_WIDTH-1:2+IDX_W]);
  assign hit   = line.valid && (line.tag == tag);
  assign merge = lane_merge(WD, A[1:0], dataType);

  dcache_lines #(.SETS(SETS)) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_line (line),
    .we      (lines_we),
    .wr_idx  (idx),
    .wr_be   (wr_be),
    .wr_line (wr_line)
  );

  always_comb begin
    state_d       = state_q;
    wr_hit_d      = wr_hit_q;
    lines_we      = 1'b0;
    wr_be         = merge.be;
    wr_line.valid = 1'b1;
    wr_line.tag   = tag;
    wr_line.data  = merge.data;
    unique case (state_q)
      IDLE: begin
        if (WE) begin
          state_d  = WRITE;
          wr_hit_d = hit;
        end else if (RE && !hit) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          lines_we     = 1'b1;
          wr_be        = 4'b1111;
          wr_line.data = mem_rdata;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          // Write-through without allocate: only refresh a line that hit.
          lines_we = wr_hit_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_hit_q <= wr_hit_d;
    end
  end

  assign mem_req   = !rst && (state_q != IDLE);
  assign mem_we    = !rst && (state_q == WRITE);
  assign mem_addr  = {A[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_wdata = merge.data;
  assign mem_be    = (state_q == FILL) ? 4'b1111 : merge.be;

  assign Stall = !rst && (
    ((state_q == IDLE) && (WE || (RE && !hit))) ||
    (state_q == FILL) ||
    ((state_q == WRITE) && !mem_ack));

  assign Result = ResultSrc ? lane_extract(line.data, A[1:0], dataType)
                            : DATA_WIDTH'(A);

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == IDLE && RE && !WE && hit && hit_q != '1)
      hit_d = hit_q + 32'd1;
    if (state_q == IDLE && state_d == FILL && miss_q != '1)
      miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Scoreboard bench for dcache_mem_stage with a fixed-latency memory model.
// Stats counters are checked when DCACHE_STATS_EN is defined.
module tb_dcache_mem_stage;
  import dcache_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WE = 1'b0;
  logic        RE = 1'b0;
  logic [1:0]  dataType = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic        ResultSrc = 1'b0;
  logic [31:0] Result;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_mem_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .WE        (WE),
    .RE        (RE),
    .dataType  (dataType),
    .A         (A),
    .WD        (WD),
    .ResultSrc (ResultSrc),
    .Result    (Result),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  logic [31:0] rq [$];
  logic [67:0] wq [$];
  logic [31:0] memw [logic [31:0]];
  int          cnt = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return memw.exists(a) ? memw[a] : 32'h0;
  endfunction

  // Memory responds LAT cycles after the request appears, then acks.
  always @(posedge clk) begin
    logic [31:0] w;
    #2;
    if (rst || !mem_req) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else begin
      cnt++;
      if (cnt == LAT + 1) begin
        if (mem_we) begin
          w = rd(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          memw[mem_addr] = w;
        end else begin
          mem_rdata = rd(mem_addr);
        end
        mem_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    logic [67:0] ew;
    if (!rst && RE && !WE && ResultSrc && !Stall) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: got %h, none expected", Result);
      end else begin
        e = rq.pop_front();
        if (Result !== e) begin
          errors++;
          $display("FAIL load_result: got %h, want %h (A=%h)", Result, e, A);
        end
      end
    end
    if (!rst && mem_req && mem_we && mem_ack) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr %h", mem_addr);
      end else begin
        ew = wq.pop_front();
        if ({mem_addr, mem_be, mem_wdata} !== ew) begin
          errors++;
          $display("FAIL mem_write: got %h/%b/%h, want %h/%b/%h",
                   mem_addr, mem_be, mem_wdata,
                   ew[67:36], ew[35:32], ew[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic wait_stall(input string name, input int exp_stall);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall never dropped", name);
    end else begin
      chk({name, "_stall"}, n, exp_stall);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] dt,
                         input logic [31:0] exp, input int exp_stall);
    A = a;
    dataType = dt;
    ResultSrc = 1'b1;
    WE = 1'b0;
    RE = 1'b1;
    rq.push_back(exp);
    exp_hits++;
    if (exp_stall != 0) exp_miss++;
    wait_stall("load", exp_stall);
    @(posedge clk);
    #1 RE = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] dt,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] wdata);
    A = a;
    dataType = dt;
    WD = wd;
    RE = 1'b0;
    WE = 1'b1;
    wq.push_back({a & 32'hFFFF_FFFC, be, wdata});
    wait_stall("store", LAT + 1);
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    memw[32'h40] = 32'hDEADBEEF;
    memw[32'h44] = 32'h55667788;
    memw[32'h60] = 32'hCAFEF00D;
    memw[32'h80] = 32'h11112222;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1 A = 32'h40;
    ResultSrc = 1'b0;
    @(negedge clk);
    chk("alu_pass", Result, 32'h40);
    @(posedge clk);
    #1;

    do_load(32'h40, DT_WORD, 32'hDEADBEEF, LAT + 2);
    do_load(32'h40, DT_WORD, 32'hDEADBEEF, 0);
    do_load(32'h43, DT_BYTE, 32'hFFFFFFDE, 0);
    do_load(32'h43, DT_UBYTE, 32'h000000DE, 0);
    do_load(32'h40, DT_HALF, 32'hFFFFBEEF, 0);
    do_load(32'h41, DT_HALF, 32'hFFFFBEEF, 0);

    do_store(32'h42, DT_HALF, 32'h00001234, 4'b1100, 32'h12340000);
    do_load(32'h40, DT_WORD, 32'h1234BEEF, 0);

    do_store(32'h81, DT_BYTE, 32'h000000AB, 4'b0010, 32'h0000AB00);
    do_load(32'h80, DT_WORD, 32'h1111AB22, LAT + 2);

    do_load(32'h40, DT_WORD, 32'h1234BEEF, LAT + 2);
    do_load(32'h60, DT_WORD, 32'hCAFEF00D, LAT + 2);
    do_load(32'h62, DT_HALF, 32'hFFFFCAFE, 0);
    do_load(32'h40, DT_WORD, 32'h1234BEEF, LAT + 2);
    do_load(32'h44, DT_WORD, 32'h55667788, LAT + 2);
    do_load(32'h44, DT_UBYTE, 32'h00000088, 0);

    A = 32'h100;
    dataType = DT_WORD;
    ResultSrc = 1'b1;
    RE = 1'b1;
    @(posedge clk);
    #1 chk("fill_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_req", {31'b0, mem_req}, 32'd0);
    chk("abort_stall", {31'b0, Stall}, 32'd0);
    RE = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_load(32'h44, DT_WORD, 32'h55667788, LAT + 2);
    do_load(32'h40, DT_WORD, 32'h1234BEEF, LAT + 2);
    do_load(32'h40, DT_BYTE, 32'hFFFFFFEF, 0);

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
`endif

    repeat (3) @(posedge clk);
    chk("rq_drained", rq.size(), 32'd0);
    chk("wq_drained", wq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_mem_stage.md
# dcache_mem_stage

Memory-stage data path with a direct-mapped, write-through data cache in front of a handshaked backing memory. It replaces the single-cycle data RAM plus result mux. It keeps the byte/half/word access types and the ALU-result/load-data selection, and adds a `Stall` output that holds the pipeline during misses and stores. It sits between the ALU result and the write-back mux; the backing memory is external.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; fixed at 32 (byte lanes assume 4)
- `SETS`, 8, cache lines (power of two, ≥2); one word per line
- `clk` in 1 — rising-edge clock
- `rst` in 1 — asynchronous, active-high reset
- `WE` in 1 — store request
- `RE` in 1 — load request
- `dataType` in 2 — 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- `A` in ADDRESS_WIDTH — ALU result / byte address
- `WD` in DATA_WIDTH — store data, right-aligned
- `ResultSrc` in 1 — 1: load data, 0: `A`
- `Result` out DATA_WIDTH — selected result
- `Stall` out 1 — hold pipeline inputs stable while 1
- `mem_req` out 1 — backing-memory request
- `mem_we` out 1 — request is a write
- `mem_addr` out ADDRESS_WIDTH — word-aligned address (`A[1:0]`=0)
- `mem_wdata` out DATA_WIDTH — write word
- `mem_be` out 4 — write byte enables
- `mem_rdata` in DATA_WIDTH — read word, valid with `mem_ack`
- `mem_ack` in 1 — one-cycle completion pulse

## Operation
- Index = `A[2+:log2(SETS)]`; tag = remaining upper bits; per line: valid, tag, data word.
- Hit = `valid[index]` and tag match.
- Access sizes: half uses `A[1]` (A[0] ignored); byte uses `A[1:0]`; word ignores `A[1:0]`.
- Loads: lane extracted, then sign- or zero-extended per `dataType`.
- FSM states IDLE, FILL, WRITE:
  - IDLE, `WE`=1 (wins over `RE`) → WRITE.
  - IDLE, `RE`=1 and miss → FILL.
  - Otherwise stay in IDLE.
  - FILL: on `mem_ack`, write `mem_rdata`, tag and valid into the line → IDLE.
  - WRITE: on `mem_ack` → IDLE. If the line hit at request time, merge the enabled bytes of `WD` into the cached word in the same edge.
- Write-through, no write-allocate: a store miss does not touch the cache.
- `mem_req` = state≠IDLE.
- `mem_we` = (state==WRITE).
- `mem_be` and `mem_wdata` are lane-shifted from `dataType`/`A`; `mem_be`=1111 during FILL.
- `Stall` = (IDLE and (`WE` or (`RE` and miss))) or FILL or (WRITE and not `mem_ack`).
- `Result` is combinational: `ResultSrc` ? extended load data : `A`. Load data is valid when `Stall`=0.

## Timing
- Reset values: state IDLE, all valid bits 0. While in IDLE with no request: `mem_req`=0, `mem_we`=0, `Stall`=0.
- Load hit: 0 added cycles; `Result` valid in the same cycle.
- Load miss: `Stall`=1 from the request cycle through the `mem_ack` cycle. The hit completes on the cycle after return to IDLE, so latency is 2 + memory latency.
- Store: `Stall`=1 in the IDLE cycle. It deasserts in the WRITE cycle where `mem_ack`=1, so latency is 1 + memory latency.
- Inputs must stay stable while `Stall`=1. `mem_addr`/`mem_wdata`/`mem_be` are derived from the held inputs and are stable while `mem_req`=1.
- `mem_ack` outside FILL/WRITE is ignored.
- Reset mid-FILL/WRITE: abort immediately, `mem_req` drops, the line is not written. The memory must tolerate a withdrawn request.
- Index aliasing: a fill overwrites the line regardless of its previous contents.

## Configuration
- `DCACHE_STATS_EN` defined: adds 32-bit output counters `hit_count` and `miss_count`, both reset to 0.
  - `hit_count` increments once per load hit that completes with `Stall`=0.
  - `miss_count` increments on each IDLE→FILL transition.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent.

## Structure
- Package `dcache_pkg`:
  - dataType encoding constants.
  - FSM state enum.
  - Line struct (valid, tag, data).
  - Functions: `lane_extract` (load extension), `lane_merge` (store byte enables plus shifted data).
- One sub-module, `dcache_lines`: the valid/tag/data array.
  - Asynchronous read.
  - Synchronous write port with per-byte enable.
  - Asynchronous clear of the valid bits on `rst`.
- FSM, stall logic and result mux live in the top module.

## Test plan
- After reset, RE=1, A=0x40, word, memory returns 0xDEADBEEF after 3 cycles → `Stall`=1 for 5 cycles; next cycle `Result`=0xDEADBEEF with `Stall`=0; repeat of the same load hits with `Stall`=0 immediately.
- Cached 0x40=0xDEADBEEF; load byte signed A=0x43 → 0xFFFFFFDE; byte unsigned → 0x000000DE; half signed A=0x40 → 0xFFFFBEEF.
- Store half WD=0x1234 to cached A=0x42 → `mem_be`=1100, `mem_wdata`=0x12340000; subsequent word load hits and returns 0x1234BEEF.
- Store miss to A=0x80 → memory write issued; later load of 0x80 misses (no allocate).
- Aliasing: A=0x40 then A=0x60 with SETS=8 → second access misses and evicts; reload of 0x40 misses again.
- Reset asserted two cycles into a FILL → `mem_req`=0 and `Stall`=0 immediately; no line valid. With `DCACHE_STATS_EN`, counters match the hits and misses issued.
